// File: rtl/pc_unit.sv
// Program-counter sequencer feeding the instruction-fetch stage.
// Issues one fetch per instruction and selects the next PC after commit.
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        pc_ready,
    output logic [31:0] pc_in,
    input  logic        inst_valid,
    input  logic        commit_valid,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        halted,
    output logic        misalign_err,
    output logic [63:0] cycle_cnt,
    output logic [63:0] retire_cnt
);

    typedef enum logic [2:0] {
        BOOT,
        ISSUE,
        WAIT_INST,
        WAIT_COMMIT,
        HALTED
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic        mis_nxt;
    logic        retire;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            misalign_err <= 1'b0;
            cycle_cnt    <= 64'd0;
            retire_cnt   <= 64'd0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            misalign_err <= mis_nxt;
            if (state != HALTED)
                cycle_cnt <= cycle_cnt + 64'd1;
            if (retire)
                retire_cnt <= retire_cnt + 64'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        mis_nxt   = misalign_err;
        retire    = 1'b0;
        unique case (state)
            BOOT:      state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_INST;
            WAIT_INST: begin
                if (inst_valid)
                    state_nxt = WAIT_COMMIT;
            end
            WAIT_COMMIT: begin
                if (commit_valid) begin
                    retire = 1'b1;
                    if (halt_req) begin
                        state_nxt = HALTED;
                    end else if (redirect_valid) begin
                        pc_nxt = redirect_pc;
                        // a misaligned target is recorded, then the core stops
                        if (|redirect_pc[1:0]) begin
                            mis_nxt   = 1'b1;
                            state_nxt = HALTED;
                        end else begin
                            state_nxt = ISSUE;
                        end
                    end else begin
                        pc_nxt    = pc + 32'd4;
                        state_nxt = ISSUE;
                    end
                end
            end
            HALTED:    state_nxt = HALTED;
            default:   state_nxt = BOOT;
        endcase
    end

    assign pc_ready = (state == ISSUE);
    assign halted   = (state == HALTED);
    assign pc_in    = pc;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: cycle-accurate instruction-level model plus
// hand-computed pins on fetch addresses, counters and reset behaviour.
module tb_pc_unit;

    logic        clock;
    logic        reset;
    logic        pc_ready;
    logic [31:0] pc_in;
    logic        inst_valid;
    logic        commit_valid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        halted;
    logic        misalign_err;
    logic [63:0] cycle_cnt;
    logic [63:0] retire_cnt;

    int vectors;
    int miscompares;

    // model: phase 0 boot, 1 fetch request, 2 awaiting inst,
    // 3 awaiting commit, 4 stopped
    int          m_phase;
    logic [31:0] m_pc;
    bit          m_mis;
    logic [63:0] m_cyc;
    logic [63:0] m_ret;

    pc_unit #(.RESET_PC(32'h3000_0000)) dut (
        .clock          (clock),
        .reset          (reset),
        .pc_ready       (pc_ready),
        .pc_in          (pc_in),
        .inst_valid     (inst_valid),
        .commit_valid   (commit_valid),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted),
        .misalign_err   (misalign_err),
        .cycle_cnt      (cycle_cnt),
        .retire_cnt     (retire_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_pc    = 32'h3000_0000;
        m_mis   = 0;
        m_cyc   = 0;
        m_ret   = 0;
    endtask

    task automatic model_step();
        if (m_phase != 4)
            m_cyc = m_cyc + 1;
        case (m_phase)
            0: m_phase = 1;
            1: m_phase = 2;
            2: if (inst_valid) m_phase = 3;
            3: if (commit_valid) begin
                m_ret = m_ret + 1;
                if (halt_req) begin
                    m_phase = 4;
                end else if (redirect_valid) begin
                    m_pc = redirect_pc;
                    if (redirect_pc % 4 != 0) begin
                        m_mis   = 1;
                        m_phase = 4;
                    end else begin
                        m_phase = 1;
                    end
                end else begin
                    m_pc    = m_pc + 32'd4;
                    m_phase = 1;
                end
            end
            default: m_phase = 4;
        endcase
    endtask

    always @(negedge clock) begin
        chk("pc_ready", {63'd0, pc_ready}, {63'd0, m_phase == 1});
        chk("pc_in", {32'd0, pc_in}, {32'd0, m_pc});
        chk("halted", {63'd0, halted}, {63'd0, m_phase == 4});
        chk("misalign_err", {63'd0, misalign_err}, {63'd0, m_mis});
        chk("cycle_cnt", cycle_cnt, m_cyc);
        chk("retire_cnt", retire_cnt, m_ret);
    end

    // one clock: hold inputs across the edge, step model, end at edge+1
    task automatic cyc(input bit iv, input bit cv, input bit rv,
                       input logic [31:0] rpc, input bit hr);
        inst_valid     = iv;
        commit_valid   = cv;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt_req       = hr;
        @(posedge clock);
        if (!reset)
            model_step();
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 32'h0, 0);
    endtask

    // from a fetch-request cycle, run one minimum-latency instruction
    task automatic instr(input bit rv, input logic [31:0] rpc, input bit hr);
        idle();
        cyc(1, 0, 0, 32'h0, 0);
        cyc(0, 1, rv, rpc, hr);
    endtask

    task automatic release_reset();
        reset = 1'b0;
        idle();
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_pc_ready", {63'd0, pc_ready}, 64'd0);
        chk("rst_pc_in", {32'd0, pc_in}, 64'h3000_0000);
        chk("rst_cycle_cnt", cycle_cnt, 64'd0);
        chk("rst_retire_cnt", retire_cnt, 64'd0);
        chk("rst_halted", {63'd0, halted}, 64'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_reset();
        reset = 1'b1;
        idle();
        idle();

        release_reset();
        chk("first_ready", {63'd0, pc_ready}, 64'd1);
        chk("fetch0", {32'd0, pc_in}, 64'h3000_0000);
        chk("cyc_at_first_fetch", cycle_cnt, 64'd1);
        instr(0, 32'h0, 0);
        chk("fetch1", {32'd0, pc_in}, 64'h3000_0004);
        chk("cyc_at_cycle5", cycle_cnt, 64'd4);
        instr(0, 32'h0, 0);
        chk("fetch2", {32'd0, pc_in}, 64'h3000_0008);
        instr(1, 32'h8000_0100, 0);
        chk("retire_after3", retire_cnt, 64'd3);
        chk("redirect", {32'd0, pc_in}, 64'h8000_0100);
        chk("redirect_ready", {63'd0, pc_ready}, 64'd1);
        instr(0, 32'h0, 0);
        chk("after_redirect", {32'd0, pc_in}, 64'h8000_0104);

        // spurious pulses in the wrong states
        cyc(1, 1, 1, 32'h1234_5678, 1);
        cyc(0, 1, 1, 32'h1234_5679, 1);
        cyc(0, 1, 0, 32'h0, 0);
        cyc(1, 1, 1, 32'h4444_4444, 1);
        cyc(1, 0, 1, 32'h5555_5555, 1);
        cyc(1, 0, 0, 32'h0, 0);
        chk("spurious_retire", retire_cnt, 64'd4);
        cyc(0, 1, 1, 32'hFFFF_FFFC, 0);
        chk("to_top", {32'd0, pc_in}, 64'hFFFF_FFFC);
        instr(0, 32'h0, 0);
        chk("wrap", {32'd0, pc_in}, 64'h0);
        chk("wrap_ready", {63'd0, pc_ready}, 64'd1);

        // async reset while waiting for the instruction
        idle();
        async_reset();
        release_reset();
        chk("resume_fetch", {32'd0, pc_in}, 64'h3000_0000);
        chk("resume_ready", {63'd0, pc_ready}, 64'd1);

        instr(1, 32'h8000_0102, 0);
        chk("mis_flag", {63'd0, misalign_err}, 64'd1);
        chk("mis_halted", {63'd0, halted}, 64'd1);
        chk("mis_pc", {32'd0, pc_in}, 64'h8000_0102);
        chk("mis_retire", retire_cnt, 64'd1);
        repeat (4) cyc(1, 1, 0, 32'h0, 0);
        chk("mis_no_fetch", {63'd0, pc_ready}, 64'd0);

        async_reset();
        release_reset();
        instr(1, 32'h8000_0200, 1);
        chk("halt_halted", {63'd0, halted}, 64'd1);
        chk("halt_pc", {32'd0, pc_in}, 64'h3000_0000);
        chk("halt_no_mis", {63'd0, misalign_err}, 64'd0);
        repeat (10) cyc(1, 1, 1, 32'h8000_0300, 0);
        chk("halt_cyc_frozen", cycle_cnt, 64'd4);
        chk("halt_retire", retire_cnt, 64'd1);

        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter sequencer that sits directly upstream of the instruction-fetch stage in the single-issue multicycle core. It owns the architectural PC and issues one fetch request per instruction on `pc_ready`/`pc_in`. After the fetched instruction commits, it waits for writeback and then selects the next PC: sequential, or redirected by a branch, jump or trap. It also detects halts and misaligned targets, and keeps cycle and retire counters.

## Interface
Parameters:
- RESET_PC, 32'h3000_0000, first fetch address after reset.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- pc_ready  out  1  one-cycle fetch request to the IFU.
- pc_in  out  32  fetch address; valid whenever pc_ready=1.
- inst_valid  in  1  IFU pulse: instruction for the current PC has been captured.
- commit_valid  in  1  writeback pulse: current instruction retired.
- redirect_valid  in  1  with commit_valid: next PC is redirect_pc.
- redirect_pc  in  32  redirect target.
- halt_req  in  1  with commit_valid: retired instruction was ebreak.
- halted  out  1  core stopped; no further fetches.
- misalign_err  out  1  sticky flag: a redirect target had pc[1:0]≠0.
- cycle_cnt  out  64  cycles since reset, frozen while halted.
- retire_cnt  out  64  number of retired instructions.

## Operation
- States: BOOT, ISSUE, WAIT_INST, WAIT_COMMIT, HALTED. All are registered.
- BOOT → ISSUE: unconditionally on the first edge after reset deasserts.
- ISSUE: pc_ready=1 for exactly one cycle, with pc_in=pc. Next state is WAIT_INST.
- WAIT_INST: stay until inst_valid=1, then go to WAIT_COMMIT.
- WAIT_COMMIT: stay until commit_valid=1. Then, in priority order:
  - halt_req=1 → go to HALTED; pc is unchanged.
  - redirect_valid=1 and redirect_pc[1:0]≠0 → set misalign_err=1, set pc=redirect_pc, go to HALTED.
  - redirect_valid=1 → set pc=redirect_pc, go to ISSUE.
  - otherwise → set pc=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), go to ISSUE.
- HALTED: terminal state. Only reset leaves it; pc_ready stays 0.
- retire_cnt increments by 1 on every commit_valid accepted in WAIT_COMMIT, including a halting commit.
- cycle_cnt increments by 1 every cycle in BOOT, ISSUE, WAIT_INST and WAIT_COMMIT. It holds in HALTED.
- Both counters wrap at 2^64.
- Ignored inputs:
  - inst_valid outside WAIT_INST.
  - commit_valid outside WAIT_COMMIT.
  - redirect_valid and halt_req whenever commit_valid=0 or the state is not WAIT_COMMIT.

## Timing
- Reset values: state=BOOT, pc=RESET_PC, pc_ready=0, pc_in=RESET_PC, halted=0, misalign_err=0, cycle_cnt=0, retire_cnt=0.
- pc_in always equals the pc register; pc_ready and halted are decoded from the registered state. No combinational path from any input to any output.
- The first pc_ready occurs in the 2nd cycle after reset deasserts (BOOT, then ISSUE).
- inst_valid to state WAIT_COMMIT: 1 edge.
- commit_valid to the next pc_ready: 1 edge, so pc_ready is high in the cycle after the commit.
- Minimum loop is 3 cycles per instruction (ISSUE, WAIT_INST, WAIT_COMMIT) when inst_valid and commit_valid each arrive in the first cycle of their state.
- inst_valid arriving in the same cycle as pc_ready is ignored, because the state is still ISSUE. The IFU cannot produce it that early.
- Reset asserted mid-operation: all outputs return to their reset values immediately, without waiting for a clock edge. An outstanding fetch is abandoned. The IFU's own reset discards its state.

## Test plan
- Reset release, then inst_valid in the 1st WAIT_INST cycle and commit_valid in the 1st WAIT_COMMIT cycle, repeated 3× → pc_ready pulses in cycles 2, 5, 8 with pc_in=0x3000_0000, 0x3000_0004, 0x3000_0008; retire_cnt=3.
- Commit with redirect_valid=1, redirect_pc=0x8000_0100 → next pc_ready carries pc_in=0x8000_0100; with no redirect, the following fetch is 0x8000_0104.
- Commit with redirect_valid=1, redirect_pc=0x8000_0102 → misalign_err=1, halted=1, pc_in=0x8000_0102, pc_ready stays 0; retire_cnt is incremented.
- Commit with halt_req=1 and redirect_valid=1 together → halted=1, pc unchanged, misalign_err=0; cycle_cnt frozen over the next 10 cycles.
- pc=0xFFFF_FFFC with a sequential commit → next pc_in=0x0000_0000. Spurious inst_valid/commit_valid pulses in the wrong states cause no state or counter change.
- Assert reset asynchronously while in WAIT_INST, mid-cycle → pc_ready=0, pc_in=0x3000_0000 and counters=0 before the next edge; fetch resumes normally after release.
